// File: rtl/painterengine_gpu_dma_burst_reader_if.sv
// AXI4 read-address / read-data channel bundle for the GPU burst reader.
interface painterengine_gpu_dma_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arvalid;
    logic                  arready;
    logic                  rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/painterengine_gpu_dma_burst_reader.sv
// Multi-channel AXI4 read-DMA master: splits one linear stream per start into MAX_BURST/4 KB-safe bursts.
// Optional GPU_READER_RRESP_CHECK_EN turns any non-OKAY RRESP into a slave-response error.
module painterengine_gpu_dma_burst_reader #(
    parameter int CHANNELS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_BURST    = 256,
    parameter int TIMEOUT_BITS = 19
) (
    input  logic                           i_wire_clock,
    input  logic                           i_wire_resetn,
    input  logic                           i_wire_start,
    input  logic                           i_wire_clear,
    input  logic [CHANNELS-1:0]            i_wire_router,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] i_wire_address,
    input  logic [CHANNELS*32-1:0]         i_wire_length,
    output logic                           o_wire_busy,
    output logic                           o_wire_done,
    output logic                           o_wire_error,
    output logic [2:0]                     o_wire_error_type,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
    output logic [CHANNELS-1:0]            o_wire_data_valid,
    output logic [CHANNELS-1:0]            o_wire_data_last,
    input  logic [CHANNELS-1:0]            i_wire_data_next,
    painterengine_gpu_dma_burst_reader_if.master m_axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MB_W  = $clog2(MAX_BURST);
    localparam int EXT_W = ADDR_WIDTH + 33;

    localparam logic [2:0] ERR_ROUTER = 3'd1;
    localparam logic [2:0] ERR_PARAM  = 3'd2;
    localparam logic [2:0] ERR_AR_TO  = 3'd3;
    localparam logic [2:0] ERR_R_TO   = 3'd4;
    localparam logic [2:0] ERR_PROTO  = 3'd5;
    localparam logic [2:0] ERR_RESP   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_DONE, S_ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [31:0]             len_reg, len_next;
    logic [31:0]             offset_reg, offset_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [8:0]              beats_reg, beats_next;
    logic [7:0]              arlen_reg, arlen_next;
    logic [8:0]              burst_cnt_reg, burst_cnt_next;
    logic [TIMEOUT_BITS-1:0] watchdog_reg, watchdog_next;
    logic [2:0]              error_type_reg, error_type_next;

    logic [IDX_W-1:0]      router_idx;
    logic [EXT_W-1:0]      end_ext;
    logic                  check_bad;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [32:0]           remain_w, win_w, page_w, beats_w;
    logic                  ar_fire, rready, beat, burst_end, resp_bad;
    logic [31:0]           offset_sum;
    logic                  unused_ok;

    always_comb begin
        router_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_wire_router[i]) router_idx = IDX_W'(i);
        end
    end

    // Wide compare so base+len*BYTES landing exactly on 2^ADDR_WIDTH is still legal.
    assign end_ext   = EXT_W'(base_reg) + (EXT_W'(len_reg) << SZ);
    assign check_bad = (base_reg[SZ-1:0] != '0) || (len_reg == 32'd0) ||
                       (end_ext > (EXT_W'(1) << ADDR_WIDTH));

    // Burst size: limited by remaining beats, the MAX_BURST window and the 4 KB page.
    always_comb begin
        calc_addr = base_reg + (ADDR_WIDTH'(offset_reg) << SZ);
        remain_w  = {1'b0, len_reg - offset_reg};
        win_w     = 33'(MAX_BURST) - 33'(calc_addr[SZ +: MB_W]);
        page_w    = 33'((13'h1000 - {1'b0, calc_addr[11:0]}) >> SZ);
        beats_w   = remain_w;
        if (win_w < beats_w)  beats_w = win_w;
        if (page_w < beats_w) beats_w = page_w;
    end

    assign ar_fire    = (state_reg == S_ADDR) && m_axi.arready;
    assign rready     = (state_reg == S_DATA) && i_wire_data_next[idx_reg];
    assign beat       = m_axi.rvalid && rready;
    assign burst_end  = (burst_cnt_reg == beats_reg - 9'd1);
    assign offset_sum = offset_reg + 32'(beats_reg);

`ifdef GPU_READER_RRESP_CHECK_EN
    assign resp_bad = (m_axi.rresp != 2'b00);
`else
    assign resp_bad = 1'b0;
`endif
    assign unused_ok = ^{m_axi.rid, m_axi.rresp};

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            base_reg       <= '0;
            len_reg        <= '0;
            offset_reg     <= '0;
            addr_reg       <= '0;
            beats_reg      <= '0;
            arlen_reg      <= '0;
            burst_cnt_reg  <= '0;
            watchdog_reg   <= '0;
            error_type_reg <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            base_reg       <= base_next;
            len_reg        <= len_next;
            offset_reg     <= offset_next;
            addr_reg       <= addr_next;
            beats_reg      <= beats_next;
            arlen_reg      <= arlen_next;
            burst_cnt_reg  <= burst_cnt_next;
            watchdog_reg   <= watchdog_next;
            error_type_reg <= error_type_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        base_next       = base_reg;
        len_next        = len_reg;
        offset_next     = offset_reg;
        addr_next       = addr_reg;
        beats_next      = beats_reg;
        arlen_next      = arlen_reg;
        burst_cnt_next  = burst_cnt_reg;
        error_type_next = error_type_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (i_wire_start) begin
                    if (!$onehot(i_wire_router)) begin
                        state_next      = S_ERROR;
                        error_type_next = ERR_ROUTER;
                    end else begin
                        idx_next   = router_idx;
                        base_next  = i_wire_address[int'(router_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        len_next   = i_wire_length[int'(router_idx)*32 +: 32];
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (check_bad) begin
                    state_next      = S_ERROR;
                    error_type_next = ERR_PARAM;
                end else begin
                    offset_next = '0;
                    state_next  = S_CALC;
                end
            end
            S_CALC: begin
                addr_next  = calc_addr;
                beats_next = 9'(beats_w);
                arlen_next = 8'(beats_w - 33'd1);
                state_next = S_ADDR;
            end
            S_ADDR: begin
                if (ar_fire) begin
                    burst_cnt_next = '0;
                    state_next     = S_DATA;
                end else if (watchdog_reg[TIMEOUT_BITS-1]) begin
                    state_next      = S_ERROR;
                    error_type_next = ERR_AR_TO;
                end
            end
            S_DATA: begin
                if (beat) begin
                    if (resp_bad) begin
                        state_next      = S_ERROR;
                        error_type_next = ERR_RESP;
                    end else if (burst_end) begin
                        if (!m_axi.rlast) begin
                            state_next      = S_ERROR;
                            error_type_next = ERR_PROTO;
                        end else begin
                            offset_next = offset_sum;
                            state_next  = (offset_sum == len_reg) ? S_DONE : S_CALC;
                        end
                    end else if (m_axi.rlast) begin
                        state_next      = S_ERROR;
                        error_type_next = ERR_PROTO;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 9'd1;
                    end
                end else if (watchdog_reg[TIMEOUT_BITS-1]) begin
                    state_next      = S_ERROR;
                    error_type_next = ERR_R_TO;
                end
            end
            S_ERROR: begin
                if (i_wire_clear) begin
                    state_next      = S_IDLE;
                    error_type_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if ((state_next != state_reg) || ar_fire || beat)
            watchdog_next = '0;
        else if ((state_reg == S_ADDR) || (state_reg == S_DATA))
            watchdog_next = watchdog_reg + 1'b1;
        else
            watchdog_next = watchdog_reg;
    end

    always_comb begin
        o_wire_busy       = !((state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERROR));
        o_wire_done       = (state_reg == S_DONE);
        o_wire_error      = (state_reg == S_ERROR);
        o_wire_error_type = error_type_reg;
        m_axi.arid        = 1'b0;
        m_axi.araddr      = addr_reg;
        m_axi.arlen       = arlen_reg;
        m_axi.arsize      = 3'(SZ);
        m_axi.arburst     = 2'b01;
        m_axi.arlock      = 1'b0;
        m_axi.arcache     = 4'b0010;
        m_axi.arprot      = 3'b000;
        m_axi.arqos       = 4'b0000;
        m_axi.arvalid     = (state_reg == S_ADDR);
        m_axi.rready      = rready;
    end

    // Lanes follow the latched index, so router changes mid-transfer are harmless.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic sel;
            assign sel = (state_reg == S_DATA) && (idx_reg == IDX_W'(gi));
            assign o_wire_data[gi*DATA_WIDTH +: DATA_WIDTH] = sel ? m_axi.rdata : '0;
            assign o_wire_data_valid[gi] = sel && m_axi.rvalid;
            assign o_wire_data_last[gi]  = sel && m_axi.rvalid && burst_end && (offset_sum == len_reg);
        end
    endgenerate
endmodule

// File: tb/tb_painterengine_gpu_dma_burst_reader.sv
// Directed-vector bench for the GPU burst reader with a small AXI read-slave model.
`timescale 1ns/1ps
module tb_painterengine_gpu_dma_burst_reader;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic [CH-1:0]     router = '0;
    logic [CH*AW-1:0]  address = '0;
    logic [CH*32-1:0]  length = '0;
    logic              busy, done, error;
    logic [2:0]        error_type;
    logic [CH*DW-1:0]  data;
    logic [CH-1:0]     data_valid, data_last;
    logic [CH-1:0]     data_next;

    painterengine_gpu_dma_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    painterengine_gpu_dma_burst_reader #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(256), .TIMEOUT_BITS(8)
    ) dut (
        .i_wire_clock(clk), .i_wire_resetn(resetn),
        .i_wire_start(start), .i_wire_clear(clear),
        .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
        .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
        .o_wire_error_type(error_type),
        .o_wire_data(data), .o_wire_data_valid(data_valid), .o_wire_data_last(data_last),
        .i_wire_data_next(data_next),
        .m_axi(axi.master)
    );

    int errors = 0;
    int checks = 0;

    // knobs (written by main only)
    bit arready_en = 1, r_en = 1, rnd_ready = 0, flush = 0;
    int early_last = -1, bad_resp = -1;
    int ch_exp = 0, len_exp = 0, xfer_id = 0;
    logic [31:0] base_exp = '0;

    // monitor results (written by slave/monitor only)
    int beats_seen = 0, data_bad = 0, last_bad = 0, lane_bad = 0, ar_cnt = 0;
    logic [31:0] ar_addr [3];
    int          ar_len  [3];

    typedef struct { logic [31:0] addr; int len; } burst_t;

    // AXI slave + lane monitor: sample at negedge, update drives 2 ns after posedge
    initial begin
        burst_t q[$];
        burst_t nb;
        int r_beat, g_beat, last_id;
        bit ar_fire, r_fire;
        r_beat = 0; g_beat = 0; last_id = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0;
        axi.rresp = 2'b00; axi.rid = 1'b0; data_next = '1;
        forever begin
            @(negedge clk);
            if (xfer_id != last_id) begin
                last_id = xfer_id;
                beats_seen = 0; data_bad = 0; last_bad = 0; lane_bad = 0; ar_cnt = 0;
            end
            ar_fire = resetn && axi.arvalid && axi.arready;
            r_fire  = resetn && axi.rvalid && axi.rready;
            nb.addr = axi.araddr;
            nb.len  = int'(axi.arlen) + 1;
            if (ar_fire) begin
                if (ar_cnt < 3) begin
                    ar_addr[ar_cnt] = axi.araddr;
                    ar_len[ar_cnt]  = int'(axi.arlen);
                end
                ar_cnt++;
            end
            if (resetn) begin
                for (int c = 0; c < CH; c++)
                    if (c != ch_exp && data_valid[c]) lane_bad++;
                if (data_valid[ch_exp] && data_next[ch_exp]) begin
                    if (data[ch_exp*DW +: DW] !== base_exp + 32'(beats_seen*4)) data_bad++;
                    if (data_last[ch_exp] !== (beats_seen == len_exp-1)) last_bad++;
                    beats_seen++;
                end
            end
            @(posedge clk); #2;
            if (!resetn || flush) begin
                q.delete(); r_beat = 0; g_beat = 0;
            end else begin
                if (ar_fire) q.push_back(nb);
                if (r_fire && q.size() > 0) begin
                    r_beat++; g_beat++;
                    if (r_beat == q[0].len) begin
                        void'(q.pop_front());
                        r_beat = 0;
                    end
                end
            end
            axi.rvalid = r_en && (q.size() > 0);
            if (q.size() > 0) begin
                axi.rdata = q[0].addr + 32'(r_beat*4);
                axi.rlast = (r_beat == q[0].len-1) || (g_beat == early_last);
                axi.rresp = (g_beat == bad_resp) ? 2'b10 : 2'b00;
            end else begin
                axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
            end
            axi.arready = arready_en;
            data_next = rnd_ready ? CH'($urandom) : '1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode: 0 normal, 1 ARREADY off, 2 RVALID off, 3 random consumer, 4 early RLAST, 5 bad RRESP
    task automatic setup(input logic [3:0] rt, input logic [31:0] b, input int l, input int mode);
        arready_en = (mode != 1); r_en = (mode != 2); rnd_ready = (mode == 3);
        early_last = (mode == 4) ? 2 : -1;
        bad_resp   = (mode == 5) ? 1 : -1;
        ch_exp = 0;
        for (int c = CH-1; c >= 0; c--) if (rt[c]) ch_exp = c;
        for (int c = 0; c < CH; c++) begin
            address[c*AW +: AW] = 32'hDEAD_0000 + 32'(c*256);
            length[c*32 +: 32]  = 32'd7;
        end
        address[ch_exp*AW +: AW] = b;
        length[ch_exp*32 +: 32]  = 32'(l);
        base_exp = b; len_exp = l; xfer_id++;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin ok = 1; break; end
        end
    endtask

    task automatic do_clear_flush();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  router; logic [31:0] base; int len; int mode; int exp_type; int nb;
        logic [31:0] a0; int l0; logic [31:0] a1; int l1; int beats;
    } vec_t;
    vec_t vec [13];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        vec_t v;
        vec[0]  = '{4'b0100, 32'h0000_1000, 300, 0, 0, 2, 32'h1000, 255, 32'h1400, 43, 300};
        vec[1]  = '{4'b0001, 32'h0000_0FF8,   8, 3, 0, 2, 32'h0FF8,   1, 32'h1000,  5,   8};
        vec[2]  = '{4'b1000, 32'h0000_1002,   4, 0, 2, 0, 32'h0,      0, 32'h0,     0,   0};
        vec[3]  = '{4'b0110, 32'h0000_2000,   4, 0, 1, 0, 32'h0,      0, 32'h0,     0,   0};
        vec[4]  = '{4'b0010, 32'h0000_03F0,  10, 3, 0, 2, 32'h03F0,   3, 32'h0400,  5,  10};
        vec[5]  = '{4'b0001, 32'h0000_0100,   0, 0, 2, 0, 32'h0,      0, 32'h0,     0,   0};
        vec[6]  = '{4'b1000, 32'hFFFF_FFF0,   4, 0, 0, 1, 32'hFFFF_FFF0, 3, 32'h0,  0,   4};
        vec[7]  = '{4'b0100, 32'hFFFF_FFF0,   5, 0, 2, 0, 32'h0,      0, 32'h0,     0,   0};
        vec[8]  = '{4'b0001, 32'h0000_0000,   4, 1, 3, 0, 32'h0,      0, 32'h0,     0,   0};
        vec[9]  = '{4'b0010, 32'h0000_0040,   4, 2, 4, 1, 32'h0040,   3, 32'h0,     0,   0};
        vec[10] = '{4'b0100, 32'h0000_2000,   4, 4, 5, 1, 32'h2000,   3, 32'h0,     0,   3};
`ifdef GPU_READER_RRESP_CHECK_EN
        vec[11] = '{4'b1000, 32'h0000_3000,   4, 5, 6, 1, 32'h3000,   3, 32'h0,     0,   2};
`else
        vec[11] = '{4'b1000, 32'h0000_3000,   4, 5, 0, 1, 32'h3000,   3, 32'h0,     0,   4};
`endif
        vec[12] = '{4'b0010, 32'h0000_5000, 513, 3, 0, 3, 32'h5000, 255, 32'h5400, 255, 513};

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_type", error_type, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_arlen", axi.arlen, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data, 0);
        chk("arsize", axi.arsize, 2);
        chk("arcache", axi.arcache, 4'b0010);
        chk("arburst", axi.arburst, 2'b01);
        @(negedge clk); resetn = 1'b1;

        for (int r = 0; r < 13; r++) begin
            v = vec[r];
            @(posedge clk); #1;
            setup(v.router, v.base, v.len, v.mode);
            router = v.router; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; router = ~v.router;
            wait_end(5000, ok);
            chk($sformatf("v%0d_end", r), ok, 1);
            chk($sformatf("v%0d_status", r), {done, error}, (v.exp_type == 0) ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_type", r), error_type, v.exp_type);
            chk($sformatf("v%0d_arcnt", r), ar_cnt, v.nb);
            if (v.nb >= 1) begin
                chk($sformatf("v%0d_ar0addr", r), ar_addr[0], v.a0);
                chk($sformatf("v%0d_ar0len", r), ar_len[0], v.l0);
            end
            if (v.nb >= 2) begin
                chk($sformatf("v%0d_ar1addr", r), ar_addr[1], v.a1);
                chk($sformatf("v%0d_ar1len", r), ar_len[1], v.l1);
            end
            chk($sformatf("v%0d_beats", r), beats_seen, v.beats);
            chk($sformatf("v%0d_databad", r), data_bad, 0);
            chk($sformatf("v%0d_lastbad", r), last_bad, 0);
            chk($sformatf("v%0d_lanebad", r), lane_bad, 0);
            $display("xfer %0d: router=%b base=0x%08h len=%0d -> done=%0b err=%0b type=%0d ars=%0d beats=%0d",
                     r, v.router, v.base, v.len, done, error, error_type, ar_cnt, beats_seen);
            if (error) begin
                do_clear_flush();
                @(negedge clk);
                chk($sformatf("v%0d_clr_err", r), error, 0);
                chk($sformatf("v%0d_clr_type", r), error_type, 0);
            end
        end

        // clear and start together in ERROR: clear wins, start ignored
        @(posedge clk); #1;
        setup(4'b0110, 32'h0000_6000, 4, 0);
        router = 4'b0110; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_end(20, ok);
        chk("cw_err_type", error_type, 1);
        @(posedge clk); #1;
        setup(4'b0001, 32'h0000_6000, 4, 0);
        router = 4'b0001; start = 1'b1; clear = 1'b1;
        @(posedge clk); #1 start = 1'b0; clear = 1'b0;
        repeat (5) @(negedge clk);
        chk("cw_busy", busy, 0);
        chk("cw_error", error, 0);
        chk("cw_done", done, 0);
        chk("cw_arcnt", ar_cnt, 0);
        $display("xfer clear+start: busy=%0b err=%0b ars=%0d", busy, error, ar_cnt);

        // asynchronous reset in the middle of a backpressured burst
        @(posedge clk); #1;
        setup(4'b1000, 32'h0000_8000, 300, 3);
        router = 4'b1000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (beats_seen >= 40) begin ok = 1; break; end
        end
        chk("mr_progress", ok, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_arvalid", axi.arvalid, 0);
        chk("mr_araddr", axi.araddr, 0);
        chk("mr_valid", data_valid, 0);
        chk("mr_data", data, 0);
        chk("mr_rready", axi.rready, 0);
        $display("xfer reset mid-burst after %0d beats: busy=%0b valid=%b", beats_seen, busy, data_valid);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        setup(4'b0001, 32'h0000_9000, 20, 0);
        router = 4'b0001; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_end(500, ok);
        chk("mr2_end", ok, 1);
        chk("mr2_done", done, 1);
        chk("mr2_beats", beats_seen, 20);
        chk("mr2_databad", data_bad, 0);
        chk("mr2_lastbad", last_bad, 0);
        $display("xfer after reset: done=%0b beats=%0d", done, beats_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
